// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU control unit: register-file command codes,
// opcodes, ALU function codes and the sequencer state encoding.
package mcpu_pkg;

  // Register-file write modes; the encoding is shared with MCPU_Registerfile.
  typedef enum logic [1:0] {
    NORMAL_EX      = 2'd0,
    LOAD_FROM_DATA = 2'd1,
    MOV_INTERNAL   = 2'd2
  } regsetcmd_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_e;

  // IDLE..WB cycle in the low two bits; HALT sits outside the normal loop.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_WB      = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  localparam int OPC_NOP  = 0;
  localparam int OPC_ADD  = 1;
  localparam int OPC_SUB  = 2;
  localparam int OPC_AND  = 3;
  localparam int OPC_OR   = 4;
  localparam int OPC_MOV  = 5;
  localparam int OPC_LDI  = 6;
  localparam int OPC_HALT = 15;

endpackage

// File: rtl/mcpu_instr_decoder.sv
// Combinational opcode decode: ALU function, register-file command and
// classification flags (writes back / halts / undefined).
module mcpu_instr_decoder
  import mcpu_pkg::*;
#(
  parameter int OPCODE_SIZE = 4
) (
  input  logic [OPCODE_SIZE-1:0] opcode_i,
  output logic [2:0]             alu_op_o,
  output logic [1:0]             regsetcmd_o,
  output logic                   is_wb_o,
  output logic                   is_halt_o,
  output logic                   is_illegal_o
);

  always_comb begin
    alu_op_o     = ALU_ADD;
    regsetcmd_o  = NORMAL_EX;
    is_wb_o      = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (int'(opcode_i))
      OPC_NOP: ;
      OPC_ADD: begin
        is_wb_o  = 1'b1;
        alu_op_o = ALU_ADD;
      end
      OPC_SUB: begin
        is_wb_o  = 1'b1;
        alu_op_o = ALU_SUB;
      end
      OPC_AND: begin
        is_wb_o  = 1'b1;
        alu_op_o = ALU_AND;
      end
      OPC_OR: begin
        is_wb_o  = 1'b1;
        alu_op_o = ALU_OR;
      end
      OPC_MOV: begin
        is_wb_o     = 1'b1;
        regsetcmd_o = MOV_INTERNAL;
      end
      OPC_LDI: begin
        is_wb_o     = 1'b1;
        regsetcmd_o = LOAD_FROM_DATA;
      end
      OPC_HALT: is_halt_o = 1'b1;
      default:  is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcpu_control_unit.sv
// Four-cycle decode/execute/write-back sequencer feeding MCPU_Registerfile.
// Define MCPU_CTRL_ZFLAG_EN to add the zero_flag output.
module mcpu_control_unit
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int OPERAND_SIZE = 2,
  parameter int OPCODE_SIZE  = 4,
  parameter int INSTR_SIZE   = OPCODE_SIZE + 3 * OPERAND_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [INSTR_SIZE-1:0]   instr,
  input  logic [WORD_SIZE-1:0]    alu_result,
  output logic [2:0]              alu_op,
  output logic [OPERAND_SIZE-1:0] op1,
  output logic [OPERAND_SIZE-1:0] op2,
  output logic [OPERAND_SIZE-1:0] op3,
  output logic [1:0]              regsetcmd,
  output logic                    regsetwb,
  output logic [WORD_SIZE-1:0]    datatoload,
  output logic                    halted,
`ifdef MCPU_CTRL_ZFLAG_EN
  output logic                    zero_flag,
`endif
  output logic                    illegal_op
);

  state_e                  state_q, state_d;
  logic [INSTR_SIZE-1:0]   instr_q, instr_d;
  logic [OPERAND_SIZE-1:0] op1_q, op1_d;
  logic [OPERAND_SIZE-1:0] op2_q, op2_d;
  logic [OPERAND_SIZE-1:0] op3_q, op3_d;
  logic [2:0]              alu_op_q, alu_op_d;
  logic [1:0]              regsetcmd_q, regsetcmd_d;
  logic [WORD_SIZE-1:0]    datatoload_q, datatoload_d;

  logic [OPCODE_SIZE-1:0]  opcode;
  logic [WORD_SIZE-1:0]    ldi_imm;
  logic [2:0]              dec_alu_op;
  logic [1:0]              dec_cmd;
  logic                    dec_is_wb;
  logic                    dec_is_halt;
  logic                    dec_is_illegal;
  logic                    dec_is_alu;

  // instr_q stays stable until the next accept, so decode is valid in every state.
  assign opcode  = instr_q[INSTR_SIZE-1 -: OPCODE_SIZE];
  assign ldi_imm = WORD_SIZE'(instr_q[2*OPERAND_SIZE-1:0]);

  mcpu_instr_decoder #(
    .OPCODE_SIZE(OPCODE_SIZE)
  ) u_decoder (
    .opcode_i    (opcode),
    .alu_op_o    (dec_alu_op),
    .regsetcmd_o (dec_cmd),
    .is_wb_o     (dec_is_wb),
    .is_halt_o   (dec_is_halt),
    .is_illegal_o(dec_is_illegal)
  );

  assign dec_is_alu = dec_is_wb && (dec_cmd == NORMAL_EX);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    op3_d        = op3_q;
    alu_op_d     = alu_op_q;
    regsetcmd_d  = regsetcmd_q;
    datatoload_d = datatoload_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op1_d = instr_q[3*OPERAND_SIZE-1 -: OPERAND_SIZE];
        op2_d = instr_q[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
        op3_d = instr_q[OPERAND_SIZE-1:0];
        if (dec_is_alu) alu_op_d = dec_alu_op;
        if (dec_is_halt)    state_d = ST_HALT;
        else if (dec_is_wb) state_d = ST_EXECUTE;
        else                state_d = ST_IDLE;
      end
      ST_EXECUTE: begin
        regsetcmd_d = dec_cmd;
        // MOV is an internal register copy, so the data path keeps its last value.
        if (dec_cmd == NORMAL_EX)           datatoload_d = alu_result;
        else if (dec_cmd == LOAD_FROM_DATA) datatoload_d = ldi_imm;
        state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      op3_q        <= '0;
      alu_op_q     <= '0;
      regsetcmd_q  <= '0;
      datatoload_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      op3_q        <= op3_d;
      alu_op_q     <= alu_op_d;
      regsetcmd_q  <= regsetcmd_d;
      datatoload_q <= datatoload_d;
    end
  end

`ifdef MCPU_CTRL_ZFLAG_EN
  logic zero_flag_q, zero_flag_d;

  always_comb begin
    zero_flag_d = zero_flag_q;
    if (state_q == ST_WB && dec_is_alu) zero_flag_d = (datatoload_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) zero_flag_q <= 1'b0;
    else       zero_flag_q <= zero_flag_d;
  end

  assign zero_flag = zero_flag_q;
`endif

  assign instr_ready = (state_q == ST_IDLE);
  // Masked by reset so an instruction aborted in WB never strobes the register file.
  assign regsetwb    = (state_q == ST_WB) && !reset;
  assign halted      = (state_q == ST_HALT);
  assign illegal_op  = (state_q == ST_DECODE) && dec_is_illegal;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign op3         = op3_q;
  assign alu_op      = alu_op_q;
  assign regsetcmd   = regsetcmd_q;
  assign datatoload  = datatoload_q;

endmodule

// File: tb/tb_mcpu_control_unit.sv
// Self-checking bench: control unit driving a behavioural register file and ALU,
// checked by directed vectors, corner sequences and a random instruction stream.
module tb_mcpu_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [7:0] alu_result;
  logic [2:0] alu_op;
  logic [1:0] op1, op2, op3;
  logic [1:0] regsetcmd;
  logic       regsetwb;
  logic [7:0] datatoload;
  logic       halted;
  logic       illegal_op;
`ifdef MCPU_CTRL_ZFLAG_EN
  logic       zero_flag;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mcpu_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_result (alu_result),
    .alu_op     (alu_op),
    .op1        (op1),
    .op2        (op2),
    .op3        (op3),
    .regsetcmd  (regsetcmd),
    .regsetwb   (regsetwb),
    .datatoload (datatoload),
    .halted     (halted),
`ifdef MCPU_CTRL_ZFLAG_EN
    .zero_flag  (zero_flag),
`endif
    .illegal_op (illegal_op)
  );

  // Behavioural register file (alu1=reg[op2], alu2=reg[op3]) and ALU.
  logic [7:0] rf [4] = '{default: 8'h00};

  always @(posedge clk) begin
    if (regsetwb) begin
      case (regsetcmd)
        2'd0, 2'd1: rf[op1] <= datatoload;
        2'd2:       rf[op1] <= rf[op2];
        default:    ;
      endcase
    end
  end

  always_comb begin
    case (alu_op)
      3'd0:    alu_result = rf[op2] + rf[op3];
      3'd1:    alu_result = rf[op2] - rf[op3];
      3'd2:    alu_result = rf[op2] & rf[op3];
      3'd3:    alu_result = rf[op2] | rf[op3];
      default: alu_result = 8'h00;
    endcase
  end

  // Architectural reference: register contents, last loaded data word, zero flag.
  logic [7:0] m_rf [4] = '{default: 8'h00};
  logic [7:0] m_data = 8'h00;
  logic       m_zf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input int opc, input int d, input int a, input int b);
    logic [3:0] o4 = 4'(opc);
    logic [1:0] d2 = 2'(d);
    logic [1:0] a2 = 2'(a);
    logic [1:0] b2 = 2'(b);
    return {o4, d2, a2, b2};
  endfunction

  task automatic model_step(input logic [9:0] ins, output bit wb, output logic [1:0] cmd,
                            output logic [7:0] data, output bit chkd, output bit ill);
    int opc = int'(ins[9:6]);
    int d = int'(ins[5:4]);
    int a = int'(ins[3:2]);
    int b = int'(ins[1:0]);
    logic [7:0] r;
    wb = 0; cmd = 2'd0; chkd = 0; ill = 0;
    r = 8'h00;
    case (opc)
      1, 2, 3, 4: begin
        if (opc == 1)      r = m_rf[a] + m_rf[b];
        else if (opc == 2) r = m_rf[a] - m_rf[b];
        else if (opc == 3) r = m_rf[a] & m_rf[b];
        else               r = m_rf[a] | m_rf[b];
        m_rf[d] = r; m_data = r; m_zf = (r == 8'h00);
        wb = 1; cmd = 2'd0; chkd = 1;
      end
      5: begin
        m_rf[d] = m_rf[a];
        wb = 1; cmd = 2'd2; chkd = 1;
      end
      6: begin
        r = {4'h0, ins[3:0]};
        m_rf[d] = r; m_data = r;
        wb = 1; cmd = 2'd1; chkd = 1;
      end
      0, 15: ;
      default: ill = 1;
    endcase
    data = m_data;
  endtask

  // Issue one instruction from IDLE and observe the four cycles after the handshake.
  task automatic run_instr(input logic [9:0] ins, input bit exp_wb, input logic [1:0] exp_cmd,
                           input logic [7:0] exp_data, input bit chkd, input bit exp_ill,
                           input string tag);
    int         n_wait = 0;
    logic [3:0] rdy, wb, ill;
    logic [7:0] d_at = 8'h00;
    logic [1:0] c_at = 2'd0;
    while (!instr_ready && n_wait < 10) begin
      @(negedge clk);
      n_wait++;
    end
    chk({tag, "_accept"}, instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) instr_valid = 1'b0;
      rdy[c-1] = instr_ready;
      wb[c-1]  = regsetwb;
      ill[c-1] = illegal_op;
      if (c == 3) begin
        d_at = datatoload;
        c_at = regsetcmd;
      end
    end
    $display("instr %03h wb=%b ready=%b ill=%b cmd=%0d data=%02h", ins, wb, rdy, ill, c_at, d_at);
    chk({tag, "_wb_timing"}, wb, exp_wb ? 4'b0100 : 4'b0000);
    chk({tag, "_ready_timing"}, rdy, exp_wb ? 4'b1000 : 4'b1110);
    chk({tag, "_illegal"}, ill, exp_ill ? 4'b0001 : 4'b0000);
    if (exp_wb) chk({tag, "_regsetcmd"}, c_at, exp_cmd);
    if (exp_wb && chkd) chk({tag, "_datatoload"}, d_at, exp_data);
  endtask

  task automatic check_state(input string tag);
    for (int r = 0; r < 4; r++) chk($sformatf("%s_reg%0d", tag, r), rf[r], m_rf[r]);
`ifdef MCPU_CTRL_ZFLAG_EN
    chk({tag, "_zero_flag"}, zero_flag, m_zf);
`endif
  endtask

  typedef struct {
    logic [9:0] ins;
    bit         wb;
    logic [1:0] cmd;
    logic [7:0] data;
    bit         chkd;
    bit         ill;
    logic [7:0] dst;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         m_wb, m_chkd, m_ill;
    logic [1:0] m_cmd;
    logic [7:0] m_d;
    int         acc, wbn, rdyn, haltn;
    logic [15:0] mask;
    logic [9:0] b2b [4];

    tbl[0]  = '{mk(6, 1, 2, 3), 1, 2'd1, 8'h0B, 1, 0, 8'h0B};  // LDI r1,#B
    tbl[1]  = '{mk(6, 2, 3, 3), 1, 2'd1, 8'h0F, 1, 0, 8'h0F};  // LDI r2,#F
    tbl[2]  = '{mk(6, 3, 0, 1), 1, 2'd1, 8'h01, 1, 0, 8'h01};  // LDI r3,#1
    tbl[3]  = '{mk(1, 0, 2, 3), 1, 2'd0, 8'h10, 1, 0, 8'h10};  // ADD
    tbl[4]  = '{mk(2, 0, 3, 2), 1, 2'd0, 8'hF2, 1, 0, 8'hF2};  // SUB wraps
    tbl[5]  = '{mk(3, 0, 1, 2), 1, 2'd0, 8'h0B, 1, 0, 8'h0B};  // AND
    tbl[6]  = '{mk(4, 0, 3, 2), 1, 2'd0, 8'h0F, 1, 0, 8'h0F};  // OR
    tbl[7]  = '{mk(2, 0, 1, 1), 1, 2'd0, 8'h00, 1, 0, 8'h00};  // r0 = 0
    tbl[8]  = '{mk(2, 2, 0, 3), 1, 2'd0, 8'hFF, 1, 0, 8'hFF};  // r2 = 0 - 1
    tbl[9]  = '{mk(1, 1, 2, 3), 1, 2'd0, 8'h00, 1, 0, 8'h00};  // FF + 01 wraps to 0
    tbl[10] = '{mk(6, 1, 2, 3), 1, 2'd1, 8'h0B, 1, 0, 8'h0B};  // LDI r1,#B
    tbl[11] = '{mk(5, 0, 1, 0), 1, 2'd2, 8'h00, 0, 0, 8'h0B};  // MOV r0,r1
    tbl[12] = '{mk(0, 1, 2, 3), 0, 2'd0, 8'h00, 0, 0, 8'h00};  // NOP
    tbl[13] = '{mk(7, 1, 2, 3), 0, 2'd0, 8'h00, 0, 1, 8'h00};  // undefined opcode

    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_regsetwb", regsetwb, 0);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_halted", halted, 0);
    chk("rst_illegal_op", illegal_op, 0);
    chk("rst_datatoload", datatoload, 0);
    chk("rst_regsetcmd", regsetcmd, 0);

    // LDI r0,#5 aborted by reset during its EXECUTE cycle.
    instr = mk(6, 0, 1, 1);
    instr_valid = 1'b1;
    wbn = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    wbn += int'(regsetwb);
    @(negedge clk);
    wbn += int'(regsetwb);
    reset = 1'b1;
    @(negedge clk);
    wbn += int'(regsetwb);
    reset = 1'b0;
    chk("abort_ready", instr_ready, 1);
    repeat (3) begin
      @(negedge clk);
      wbn += int'(regsetwb);
    end
    $display("abort LDI wb_count=%0d reg0=%02h", wbn, rf[0]);
    chk("abort_no_wb", wbn, 0);
    chk("abort_reg0", rf[0], 8'h00);
    chk("abort_datatoload", datatoload, 8'h00);

    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].ins, m_wb, m_cmd, m_d, m_chkd, m_ill);
      run_instr(tbl[i].ins, tbl[i].wb, tbl[i].cmd, tbl[i].data, tbl[i].chkd, tbl[i].ill,
                $sformatf("vec%0d", i));
      if (tbl[i].wb) chk($sformatf("vec%0d_dst", i), rf[tbl[i].ins[5:4]], tbl[i].dst);
      check_state($sformatf("vec%0d", i));
    end
    chk("mov_src_unchanged", rf[1], 8'h0B);

    for (int i = 0; i < 40; i++) begin
      logic [9:0] ins;
      ins = mk(int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      model_step(ins, m_wb, m_cmd, m_d, m_chkd, m_ill);
      run_instr(ins, m_wb, m_cmd, m_d, m_chkd, m_ill, $sformatf("rnd%0d", i));
      check_state($sformatf("rnd%0d", i));
    end

    // instr_valid held high: accepts only every fourth cycle, each exactly once.
    b2b[0] = mk(6, 0, 0, 3);
    b2b[1] = mk(6, 1, 2, 1);
    b2b[2] = mk(6, 2, 3, 0);
    b2b[3] = mk(6, 3, 1, 2);
    for (int k = 0; k < 4; k++) model_step(b2b[k], m_wb, m_cmd, m_d, m_chkd, m_ill);
    acc = 0; wbn = 0; mask = '0;
    for (int c = 0; c < 16; c++) begin
      instr = b2b[acc < 4 ? acc : 3];
      instr_valid = 1'b1;
      if (instr_ready) begin
        mask[c] = 1'b1;
        acc++;
      end
      wbn += int'(regsetwb);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    $display("back-to-back ready_mask=%04h accepts=%0d wb_count=%0d", mask, acc, wbn);
    chk("b2b_ready_mask", mask, 16'h1111);
    chk("b2b_accepts", acc, 4);
    chk("b2b_wb_count", wbn, 4);
    check_state("b2b");

    // HALT, then valid instructions must be ignored until reset.
    instr = mk(15, 0, 0, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    chk("halt_decode_halted", halted, 0);
    chk("halt_decode_ready", instr_ready, 0);
    instr = mk(6, 0, 3, 3);
    rdyn = 0; wbn = 0; haltn = 0;
    repeat (8) begin
      @(negedge clk);
      rdyn  += int'(instr_ready);
      wbn   += int'(regsetwb);
      haltn += int'(halted);
    end
    $display("halt ready_count=%0d wb_count=%0d halted_cycles=%0d", rdyn, wbn, haltn);
    chk("halt_never_ready", rdyn, 0);
    chk("halt_no_wb", wbn, 0);
    chk("halt_sticky", haltn, 8);
    check_state("halt");
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_data = 8'h00;
    m_zf = 1'b0;
    chk("post_halt_reset_halted", halted, 0);
    chk("post_halt_reset_ready", instr_ready, 1);

    model_step(mk(6, 0, 3, 3), m_wb, m_cmd, m_d, m_chkd, m_ill);
    run_instr(mk(6, 0, 3, 3), m_wb, m_cmd, m_d, m_chkd, m_ill, "post_halt_ldi");
    check_state("post_halt");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
